// File: rtl/ddc_nch_config_router.sv
// rtl/ddc_nch_config_router.sv - config front-end fanning one upstream transfer out to a masked set of DDC channels
module ddc_nch_config_router #(
  parameter int CH_NUM       = 4,
  parameter int CONFIG_WIDTH = 32,
  parameter int CFG_WORD_NUM = 1218,
  parameter int CNT_WIDTH    = 11,
  parameter int TIMEOUT_CYC  = 65535,
  parameter int TO_WIDTH     = 16
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    isConfig,
  input  logic [CONFIG_WIDTH-1:0] Data_Config_In,
  input  logic                    Data_Config_In_Valid,
  output logic                    isConfigACK,
  output logic                    isConfigDone,
  output logic                    isConfigErr,
  output logic [1:0]              Err_Code,
  output logic [CH_NUM-1:0]       Active_Mask,
  output logic [CH_NUM-1:0]       Chan_isConfig,
  output logic [CONFIG_WIDTH-1:0] Chan_Data_Config_Out,
  output logic [CH_NUM-1:0]       Chan_Data_Config_Valid,
  input  logic [CH_NUM-1:0]       Chan_isConfigACK,
  input  logic [CH_NUM-1:0]       Chan_isConfigDone
);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    REQ,
    STREAM,
    WAIT_DONE,
    FIN,
    ERR
  } stateType;

  localparam logic [1:0]           ERR_EMPTY   = 2'd1;
  localparam logic [1:0]           ERR_TIMEOUT = 2'd2;
  localparam logic [1:0]           ERR_ABORT   = 2'd3;
  localparam logic [CNT_WIDTH-1:0] LAST_WORD   = CNT_WIDTH'(CFG_WORD_NUM - 1);
  localparam logic [TO_WIDTH-1:0]  TO_LAST     = TO_WIDTH'(TIMEOUT_CYC - 1);

  stateType                state, stateNext;
  logic [CH_NUM-1:0]       ackSticky, ackStickyNext;
  logic [CH_NUM-1:0]       doneSticky, doneStickyNext;
  logic [TO_WIDTH-1:0]     toCnt, toCntNext;
  logic [CNT_WIDTH-1:0]    wordCnt, wordCntNext;
  logic [CH_NUM-1:0]       maskNext, chanCfgNext, validNext;
  logic [1:0]              errCodeNext;
  logic [CONFIG_WIDTH-1:0] dataNext;
  logic                    ackPulseNext, donePulseNext, errPulseNext;

  logic [CH_NUM-1:0]       hdrMask;
  logic [CH_NUM-1:0]       ackSeen, doneSeen;
  logic                    ackAll, doneAll;

  // Top header bit overrides the mask field and selects every channel.
  assign hdrMask  = Data_Config_In[CONFIG_WIDTH-1] ? {CH_NUM{1'b1}} : Data_Config_In[CH_NUM-1:0];
  assign ackSeen  = ackSticky | (Chan_isConfigACK & Active_Mask);
  assign doneSeen = doneSticky | (Chan_isConfigDone & Active_Mask);
  assign ackAll   = (ackSeen == Active_Mask);
  assign doneAll  = (doneSeen == Active_Mask);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state                  <= IDLE;
      ackSticky              <= '0;
      doneSticky             <= '0;
      toCnt                  <= '0;
      wordCnt                <= '0;
      Active_Mask            <= '0;
      Err_Code               <= '0;
      Chan_isConfig          <= '0;
      Chan_Data_Config_Out   <= '0;
      Chan_Data_Config_Valid <= '0;
      isConfigACK            <= 1'b0;
      isConfigDone           <= 1'b0;
      isConfigErr            <= 1'b0;
    end else begin
      state                  <= stateNext;
      ackSticky              <= ackStickyNext;
      doneSticky             <= doneStickyNext;
      toCnt                  <= toCntNext;
      wordCnt                <= wordCntNext;
      Active_Mask            <= maskNext;
      Err_Code               <= errCodeNext;
      Chan_isConfig          <= chanCfgNext;
      Chan_Data_Config_Out   <= dataNext;
      Chan_Data_Config_Valid <= validNext;
      isConfigACK            <= ackPulseNext;
      isConfigDone           <= donePulseNext;
      isConfigErr            <= errPulseNext;
    end
  end

  always_comb begin
    stateNext      = state;
    ackStickyNext  = ackSticky;
    doneStickyNext = doneSticky;
    toCntNext      = toCnt;
    wordCntNext    = wordCnt;
    maskNext       = Active_Mask;
    errCodeNext    = Err_Code;
    chanCfgNext    = Chan_isConfig;
    dataNext       = Chan_Data_Config_Out;
    validNext      = '0;
    ackPulseNext   = 1'b0;
    donePulseNext  = 1'b0;
    errPulseNext   = 1'b0;

    case (state)
      IDLE: begin
        if (isConfig) stateNext = HDR;
      end

      HDR: begin
        if (!isConfig) begin
          stateNext = IDLE;
        end else if (Data_Config_In_Valid) begin
          if (hdrMask == '0) begin
            stateNext    = ERR;
            errCodeNext  = ERR_EMPTY;
            errPulseNext = 1'b1;
          end else begin
            stateNext     = REQ;
            maskNext      = hdrMask;
            errCodeNext   = '0;
            chanCfgNext   = hdrMask;
            ackStickyNext = '0;
            toCntNext     = '0;
          end
        end
      end

      REQ: begin
        if (!isConfig) begin
          stateNext    = ERR;
          errCodeNext  = ERR_ABORT;
          errPulseNext = 1'b1;
          chanCfgNext  = '0;
        end else if (ackAll) begin
          stateNext    = STREAM;
          ackPulseNext = 1'b1;
          wordCntNext  = '0;
        end else if (toCnt == TO_LAST) begin
          stateNext    = ERR;
          errCodeNext  = ERR_TIMEOUT;
          errPulseNext = 1'b1;
          chanCfgNext  = '0;
        end else begin
          ackStickyNext = ackSeen;
          toCntNext     = toCnt + TO_WIDTH'(1);
        end
      end

      STREAM: begin
        if (!isConfig) begin
          stateNext    = ERR;
          errCodeNext  = ERR_ABORT;
          errPulseNext = 1'b1;
          chanCfgNext  = '0;
        end else if (Data_Config_In_Valid) begin
          dataNext  = Data_Config_In;
          validNext = Active_Mask;
          if (wordCnt == LAST_WORD) begin
            stateNext      = WAIT_DONE;
            doneStickyNext = '0;
            toCntNext      = '0;
          end else begin
            wordCntNext = wordCnt + CNT_WIDTH'(1);
          end
        end
      end

      WAIT_DONE: begin
        if (!isConfig) begin
          stateNext    = ERR;
          errCodeNext  = ERR_ABORT;
          errPulseNext = 1'b1;
          chanCfgNext  = '0;
        end else if (doneAll) begin
          stateNext     = FIN;
          donePulseNext = 1'b1;
          chanCfgNext   = '0;
        end else if (toCnt == TO_LAST) begin
          stateNext    = ERR;
          errCodeNext  = ERR_TIMEOUT;
          errPulseNext = 1'b1;
          chanCfgNext  = '0;
        end else begin
          doneStickyNext = doneSeen;
          toCntNext      = toCnt + TO_WIDTH'(1);
        end
      end

      // A new transfer is only accepted once the requester has released isConfig.
      FIN: begin
        if (!isConfig) stateNext = IDLE;
      end

      ERR: begin
        chanCfgNext = '0;
        if (!isConfig) stateNext = IDLE;
      end

      default: begin
        stateNext   = IDLE;
        chanCfgNext = '0;
      end
    endcase
  end

endmodule
